// File: rtl/x_tdc_pkg.sv
// Shared types and helpers for the TDC hit decoder.
// Tap/timestamp widths, FSM state codes, popcount and bubble filter.
package x_tdc_pkg;

    localparam int TAP_W  = 32;
    localparam int CRS_W  = 16;
    localparam int FINE_W = $clog2(TAP_W) + 1;
    localparam int TS_W   = CRS_W + FINE_W;

    typedef logic [1:0] fsm_t;
    localparam fsm_t IDLE    = 2'd0;
    localparam fsm_t ARMED   = 2'd1;
    localparam fsm_t HOLDOFF = 2'd2;

    typedef logic [TAP_W-1:0] tap_t;

    typedef struct packed {
        logic [CRS_W-1:0]  coarse;
        logic [FINE_W-1:0] fine;
    } ts_t;

    function automatic logic [FINE_W-1:0] popcount(input tap_t v);
        logic [FINE_W-1:0] c;
        c = '0;
        for (int i = 0; i < TAP_W; i++)
            c = c + FINE_W'(v[i]);
        return c;
    endfunction

    // Inner taps take the 3-tap majority; the two end taps pass through.
    function automatic tap_t bubble_fix(input tap_t v);
        tap_t r;
        r = v;
        for (int k = 1; k < TAP_W - 1; k++)
            r[k] = (v[k-1] & v[k]) | (v[k] & v[k+1]) | (v[k-1] & v[k+1]);
        return r;
    endfunction

endpackage

// File: rtl/x_tdc_fifo.sv
// Timestamp FIFO: synchronous, power-of-2 depth, push/pop/full/empty.
// A push while full is accepted only if a pop happens in the same cycle.
import x_tdc_pkg::*;

module x_tdc_fifo #(
    parameter int DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_nrst,
    input  logic            push,
    input  logic [TS_W-1:0] din,
    input  logic            pop,
    output logic [TS_W-1:0] dout,
    output logic            full,
    output logic            empty
);

    localparam int AW = $clog2(DEPTH);

    logic [TS_W-1:0] mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            wr_en;
    logic            rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the queue.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents are only visible through valid pointers.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/x_tdc_decoder.sv
// TDC hit decoder: samples taps, detects hits, timestamps and queues them.
// Define BUBBLE_FILTER_EN to add a majority-filter stage before popcount.
import x_tdc_pkg::*;

module x_tdc_decoder #(
    parameter int WIDTH      = TAP_W,
    parameter int COARSE_W   = CRS_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_arm,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [COARSE_W-1:0]    o_coarse,
    output logic [$clog2(WIDTH):0] o_fine,
    output logic                   o_overflow,
    output logic                   o_armed
);

    tap_t                s0;
    tap_t                s0_prev;
    logic [COARSE_W-1:0] coarse;
    fsm_t                state;
    logic                hit;

    logic                enc_vld;
    tap_t                enc_tap;
    logic [COARSE_W-1:0] enc_coarse;

    logic                s1_vld;
    ts_t                 s1_ts;

    logic [TS_W-1:0]     head_raw;
    ts_t                 head;
    logic                full;
    logic                empty;
    logic                pop;

    assign hit = (state == ARMED) & s0[0] & ~s0_prev[0];

    // S0 snapshot register plus one cycle of history for edge detect.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            s0      <= '0;
            s0_prev <= '0;
        end else begin
            s0      <= i_data;
            s0_prev <= s0;
        end
    end

    // Free-running coarse counter, wraps silently.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) coarse <= '0;
        else         coarse <= coarse + COARSE_W'(1);
    end

    // Arm/hit/holdoff sequencing; a hit overrides a same-cycle arm.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (i_arm)     state <= ARMED;
                ARMED:   if (hit)       state <= HOLDOFF;
                HOLDOFF: if (s0 == '0)  state <= ARMED;
                default:                state <= IDLE;
            endcase
        end
    end

`ifdef BUBBLE_FILTER_EN
    // S0b: majority-filtered copy of the hit sample, coarse kept aligned.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            enc_vld    <= 1'b0;
            enc_tap    <= '0;
            enc_coarse <= '0;
        end else begin
            enc_vld    <= hit;
            enc_tap    <= bubble_fix(s0);
            enc_coarse <= coarse;
        end
    end
`else
    assign enc_vld    = hit;
    assign enc_tap    = s0;
    assign enc_coarse = coarse;
`endif

    // S1: encode timestamp; it is pushed into the FIFO on the next edge.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            s1_vld <= 1'b0;
            s1_ts  <= '0;
        end else begin
            s1_vld       <= enc_vld;
            s1_ts.coarse <= enc_coarse;
            s1_ts.fine   <= popcount(enc_tap);
        end
    end

    assign pop = o_valid & i_ready;

    x_tdc_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .push   (s1_vld),
        .din    (s1_ts),
        .pop    (pop),
        .dout   (head_raw),
        .full   (full),
        .empty  (empty)
    );

    // Sticky drop flag; a new drop wins over a same-cycle arm clear.
    always_ff @(posedge i_clk) begin
        if (!i_nrst)                  o_overflow <= 1'b0;
        else if (s1_vld & full & ~pop) o_overflow <= 1'b1;
        else if (i_arm)               o_overflow <= 1'b0;
    end

    assign head     = head_raw;
    assign o_valid  = ~empty;
    assign o_coarse = head.coarse;
    assign o_fine   = head.fine;
    assign o_armed  = (state == ARMED);

endmodule

// File: tb/tb_x_tdc_decoder.sv
// Self-checking bench for x_tdc_decoder: directed scenarios + random traffic.
// Expected outputs come from a queue-based timestamp model.
module tb_x_tdc_decoder;

    localparam int W     = 32;
    localparam int CW    = 16;
    localparam int DEPTH = 4;
`ifdef BUBBLE_FILTER_EN
    localparam int LAT     = 3;
    localparam int FB_FINE = 8;
`else
    localparam int LAT     = 2;
    localparam int FB_FINE = 7;
`endif

    logic          i_clk = 1'b0;
    logic          i_nrst = 1'b0;
    logic [W-1:0]  i_data = '0;
    logic          i_arm = 1'b0;
    logic          i_ready = 1'b0;
    logic          o_valid;
    logic [CW-1:0] o_coarse;
    logic [5:0]    o_fine;
    logic          o_overflow;
    logic          o_armed;

    always #5 i_clk = ~i_clk;

    x_tdc_decoder dut (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .i_data     (i_data),
        .i_arm      (i_arm),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_coarse   (o_coarse),
        .o_fine     (o_fine),
        .o_overflow (o_overflow),
        .o_armed    (o_armed)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct { int rem; int c; int f; } pend_t;
    typedef struct { int c; int f; } ent_t;

    logic [W-1:0] m_s0, m_s0p;
    bit           m_armed, m_hold, m_ovf;
    int           m_coarse;
    pend_t        m_pipe[$];
    ent_t         m_q[$];

    function automatic int ones(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [W-1:0] smooth(input logic [W-1:0] v);
        logic [W-1:0] r = v;
        for (int k = 1; k < W - 1; k++) begin
            int s = int'(v[k-1]) + int'(v[k]) + int'(v[k+1]);
            r[k] = (s >= 2);
        end
        return r;
    endfunction

    function automatic int fine_of(input logic [W-1:0] v);
`ifdef BUBBLE_FILTER_EN
        return ones(smooth(v));
`else
        return ones(v);
`endif
    endfunction

    task automatic model_edge(input logic [W-1:0] d, input bit arm,
                              input bit rdy, input bit nrst);
        bit   hit, pop, push, drop;
        int   occ;
        ent_t e;
        if (!nrst) begin
            m_s0 = '0; m_s0p = '0;
            m_armed = 0; m_hold = 0; m_ovf = 0;
            m_coarse = 0;
            m_pipe.delete();
            m_q.delete();
            return;
        end
        hit  = m_armed && m_s0[0] && !m_s0p[0];
        pop  = (m_q.size() > 0) && rdy;
        push = 0;
        drop = 0;
        e    = '{0, 0};
        foreach (m_pipe[i]) m_pipe[i].rem--;
        if (m_pipe.size() > 0 && m_pipe[0].rem == 0) begin
            push = 1;
            e    = '{m_pipe[0].c, m_pipe[0].f};
            void'(m_pipe.pop_front());
        end
        occ = m_q.size();
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (occ - int'(pop) < DEPTH) m_q.push_back(e);
            else                         drop = 1;
        end
        m_ovf = drop ? 1'b1 : (arm ? 1'b0 : m_ovf);
        if (hit) m_pipe.push_back('{LAT - 1, m_coarse, fine_of(m_s0)});
        if (hit) begin
            m_armed = 0; m_hold = 1;
        end else if (!m_armed && !m_hold && arm) begin
            m_armed = 1;
        end else if (m_hold && m_s0 == '0) begin
            m_hold = 0; m_armed = 1;
        end
        m_coarse = (m_coarse + 1) % (1 << CW);
        m_s0p = m_s0;
        m_s0  = d;
    endtask

    task automatic compare();
        bit v = (m_q.size() > 0);
        chk("valid",    o_valid,    v);
        chk("coarse",   o_coarse,   v ? m_q[0].c : 0);
        chk("fine",     o_fine,     v ? m_q[0].f : 0);
        chk("overflow", o_overflow, m_ovf);
        chk("armed",    o_armed,    m_armed);
    endtask

    // One clock: drive on the falling edge, model at rising, check at falling.
    task automatic step(input logic [W-1:0] d, input bit arm,
                        input bit rdy, input bit nrst);
        i_data = d; i_arm = arm; i_ready = rdy; i_nrst = nrst;
        @(posedge i_clk);
        model_edge(d, arm, rdy, nrst);
        @(negedge i_clk);
        compare();
    endtask

    task automatic do_reset();
        step('0, 0, 0, 0);
        step('0, 0, 0, 0);
    endtask

    initial begin
        int n;
        logic [W-1:0] d;

        // 1: single thermometer hit, ready high
        do_reset();
        step('0, 1, 1, 1);
        step('0, 0, 1, 1);
        repeat (4) step(32'h0000FFFF, 0, 1, 1);
        chk("t1_holdoff", o_armed, 0);
        repeat (4) step('0, 0, 1, 1);
        chk("t1_rearmed", o_armed, 1);

        // 2: bubble pattern, latency and fine value
        do_reset();
        step('0, 1, 1, 1);
        step('0, 0, 1, 1);
        step(32'h000000FB, 0, 1, 1);
        n = 1;
        while (!o_valid && n < 10) begin
            step(32'h000000FB, 0, 1, 1);
            n++;
        end
        chk("t2_lat", n, LAT + 1);
        chk("t2_fine", o_fine, FB_FINE);
        repeat (3) step('0, 0, 1, 1);

        // 3: five hits with ready low -> four queued, one dropped
        do_reset();
        step('0, 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step('1, 0, 0, 1);
            step('0, 0, 0, 1);
        end
        repeat (4) step('0, 0, 0, 1);
        chk("t3_ovf_set", o_overflow, 1);
        chk("t3_fine32", o_fine, 32);
        step('0, 1, 0, 1);
        chk("t3_ovf_clr", o_overflow, 0);
        repeat (6) step('0, 0, 1, 1);
        chk("t3_drained", o_valid, 0);

        // 4: never armed -> no timestamps
        do_reset();
        step('0, 0, 1, 1);
        repeat (6) step(32'h1, 0, 1, 1);
        chk("t4_novalid", o_valid, 0);

        // 5: hit at coarse 0xFFFF, then after wrap
        do_reset();
        step('0, 1, 1, 1);
        while (m_coarse != 16'hFFFE) step('0, 0, 1, 1);
        step(32'h1, 0, 1, 1);
        repeat (LAT) step('0, 0, 1, 1);
        chk("t5_wrap_hi", o_coarse, 16'hFFFF);
        step(32'h1, 0, 1, 1);
        repeat (LAT) step('0, 0, 1, 1);
        chk("t5_wrap_lo", o_coarse, LAT);
        chk("t5_fine", o_fine, 1);

        // 6: reset with two queued entries and a hit in flight
        do_reset();
        step('0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step('1, 0, 0, 1);
            step('0, 0, 0, 1);
        end
        step('0, 0, 0, 0);
        chk("t6_rst_valid", o_valid, 0);
        for (int i = 0; i < 6; i++) begin
            step('0, 0, 1, 1);
            chk("t6_no_stale", o_valid, 0);
        end

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: d = '0;
                4, 5:       d = (W)'((64'd1 << $urandom_range(1, W)) - 1);
                6, 7:       d = '1;
                default:    d = $urandom;
            endcase
            step(d, ($urandom_range(0, 15) == 0), $urandom_range(0, 1),
                 ($urandom_range(0, 299) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
